axi_slave_mem: RTL and testbench
================================

// Module: axi_slave_mem
// PURPOSE
//  Parametrised AXI3-style slave backed by an on-chip word memory; next generation of our fixed
//  32-bit axi_slave. Adds configurable data/addr/ID width and depth, INCR/FIXED/WRAP bursts,
//  byte strobes and SLVERR on bad accesses. Sits at the bus edge as memory/test-target endpoint.
// PARAMETERS
//  DATA_WIDTH  32   data bus width in bits; power of 2, 32..256. NB = DATA_WIDTH/8
//  ADDR_WIDTH  32   byte address width
//  ID_WIDTH    4    transaction ID width
//  MEM_DEPTH   1024 memory depth in DATA_WIDTH words; power of 2
//  BASE_ADDR   0    byte address of word 0; NB-aligned
// PORTS
//  clk        in   1            clock
//  rst        in   1            reset, asynchronous, active-high
//  i_awaddr   in   ADDR_WIDTH   write burst start address
//  i_awid     in   ID_WIDTH     write ID
//  i_awlen    in   4            beats-1 (1..16 beats)
//  i_awburst  in   2            00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  i_awvalid  in   1            / o_awready out 1: AW handshake
//  i_wdata    in   DATA_WIDTH   write data
//  i_wid      in   ID_WIDTH     write data ID
//  i_wstrb    in   NB           byte enables
//  i_wlast    in   1            last write beat
//  i_wvalid   in   1            / o_wready out 1: W handshake
//  o_bid      out  ID_WIDTH     response ID
//  o_bresp    out  2            00 OKAY, 10 SLVERR
//  o_bvalid   out  1            / i_bready in 1: B handshake
//  i_araddr, i_arid, i_arlen, i_arburst, i_arvalid in / o_arready out: as AW, read side
//  o_rdata    out  DATA_WIDTH   read data
//  o_rid      out  ID_WIDTH     read ID
//  o_rresp    out  2            00 OKAY, 10 SLVERR
//  o_rlast    out  1            last read beat
//  o_rvalid   out  1            / i_rready in 1: R handshake
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs to IDLE; memory contents NOT cleared, retained across reset.
//  Reset mid-burst aborts the burst; no response issued; beats already written stay written.
//  Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE; read FSM R_IDLE->R_READ->R_DATA, independent.
//  W_IDLE: o_awready=1; on handshake latch addr/id/len/burst, beat cnt=0, err=0 -> W_DATA.
//  W_DATA: o_wready=1; per beat write bytes where wstrb=1, advance addr, cnt++.
//   Beat cnt==len -> W_RESP. err set (sticky) if wid!=awid, wlast!=(cnt==len), beat addr out of range,
//   burst=11, or WRAP with len not in {1,3,7,15}; erroneous-address beats suppress the write.
//  W_RESP: o_bvalid=1, o_bid=latched id, o_bresp=err?10:00; held stable until i_bready -> W_IDLE.
//  R_IDLE: o_arready=1; on handshake latch fields -> R_READ.
//  R_READ: registered memory read of current addr -> R_DATA next cycle.
//  R_DATA: o_rvalid=1, o_rid, o_rlast=(cnt==len); rdata/rresp held until i_rready; then
//   last -> R_IDLE, else advance addr, cnt++ -> R_READ. First rvalid 2 cycles after AR handshake;
//   throughput 1 beat / 2 cycles with rready high. Bad beat: rresp=10, rdata=0, burst continues.
//  Addressing: word idx=(addr-BASE_ADDR)>>log2(NB); start addr low log2(NB) bits ignored.
//   Out of range: addr<BASE_ADDR or idx>=MEM_DEPTH, checked per beat.
//   FIXED: addr constant. INCR: addr+=NB, ADDR_WIDTH wrap-around. WRAP: bound=(len+1)*NB,
//   next=(addr & ~(bound-1)) | ((addr+NB) & (bound-1)).
//  Same-word write and read in one cycle: read returns old data (read-first).
//  Only one outstanding burst per direction; AW/AR ready low outside IDLE.
// TESTING
//  1 INCR write len=3 @0x10, data A0..A3, strb all-1; read back len=3 @0x10 -> rdata A0..A3,
//    rresp 00, rlast on 4th beat only, rid=arid, bresp 00, bid=awid.
//  2 Write 0x11223344 @0x40, then strb 0x3 data 0xAABBCCDD (DATA_WIDTH=32) -> read 0x1122CCDD.
//  3 WRAP len=3 @0x38 (NB=4) -> beats hit 0x38,0x3C,0x30,0x34; INCR same start -> 0x38..0x44.
//  4 Write/read @BASE_ADDR+4*MEM_DEPTH -> bresp 10, memory unchanged; rresp 10, rdata 0.
//  5 Hold i_bready=0 5 cycles -> bvalid/bid/bresp stable, awready 0; wid!=awid -> bresp 10.
//  6 rst pulse after 2 of 4 write beats -> all outputs 0; awready 1 cycle after release;
//    read of the 2 written words returns their data.

Source files
------------

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3-style slave endpoint backed by an on-chip word memory.
// Independent write (AW/W/B) and read (AR/R) engines, one burst outstanding
// per direction, FIXED/INCR/WRAP bursts, byte strobes, SLVERR on bad beats.
// Memory contents are not reset; a reset mid-burst simply abandons the burst.
module axi_slave_mem #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [3:0]              i_awlen,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [ID_WIDTH-1:0]     i_wid,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [3:0]              i_arlen,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LNB   = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(NB - 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} rstate_t;

    // Beat address lies inside the memory window.
    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> (LNB + IDX_W)) == '0);
    endfunction

    // Word index of a beat address (only meaningful when in range).
    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> LNB);
    endfunction

    // Burst type / length combinations that can never be served.
    function automatic logic f_burst_err(input logic [1:0] burst, input logic [3:0] len);
        return (burst == 2'b11) ||
               ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    endfunction

    // Address of the following beat for the given burst type.
    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                          input logic [3:0] len,
                                                          input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] wmask;
        incr  = a + ADDR_WIDTH'(NB);
        wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << LNB) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~wmask) | (incr & wmask);
            default: return incr;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    wstate_t               r_wstate;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ID_WIDTH-1:0]   r_wid;
    logic [3:0]            r_wlen;
    logic [1:0]            r_wburst;
    logic [3:0]            r_wcnt;
    logic                  r_werr;

    rstate_t               r_rstate;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [3:0]            r_rlen;
    logic [1:0]            r_rburst;
    logic [3:0]            r_rcnt;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_r_adv;
    logic w_wlast_beat, w_wbeat_ok, w_wbeat_err, w_rbeat_err;

    assign w_aw_hs      = i_awvalid & o_awready;
    assign w_w_hs       = i_wvalid & o_wready;
    assign w_ar_hs      = i_arvalid & o_arready;
    assign w_r_adv      = (r_rstate == R_DATA) & i_rready & ~o_rlast;
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_wbeat_ok   = f_in_range(r_waddr);
    assign w_wbeat_err  = (i_wid != r_wid) | (i_wlast != w_wlast_beat) | ~w_wbeat_ok
                        | f_burst_err(r_wburst, r_wlen);
    assign w_rbeat_err  = ~f_in_range(r_raddr) | f_burst_err(r_rburst, r_rlen);

    // Burst descriptors: latched on address handshake, stepped after each beat.
    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_waddr  <= i_awaddr & ~LOW_MASK;
            r_wid    <= i_awid;
            r_wlen   <= i_awlen;
            r_wburst <= i_awburst;
        end else if (w_w_hs) begin
            r_waddr  <= f_next_addr(r_waddr, r_wlen, r_wburst);
        end
        if (w_ar_hs) begin
            r_raddr  <= i_araddr & ~LOW_MASK;
            r_rid    <= i_arid;
            r_rlen   <= i_arlen;
            r_rburst <= i_arburst;
        end else if (w_r_adv) begin
            r_raddr  <= f_next_addr(r_raddr, r_rlen, r_rburst);
        end
    end

    // Byte-strobed memory write; out-of-range beats never touch the array.
    always_ff @(posedge clk) begin
        if (w_w_hs && w_wbeat_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (i_wstrb[b]) r_mem[f_idx(r_waddr)][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Write engine: accept address, collect beats, hold response until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            o_bvalid  <= 1'b0;
            o_bid     <= '0;
            o_bresp   <= 2'b00;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    o_awready <= 1'b1;
                    if (w_aw_hs) begin
                        o_awready <= 1'b0;
                        o_wready  <= 1'b1;
                        r_wcnt    <= '0;
                        r_werr    <= 1'b0;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_wcnt <= r_wcnt + 4'd1;
                        r_werr <= r_werr | w_wbeat_err;
                        if (w_wlast_beat) begin
                            o_wready <= 1'b0;
                            o_bvalid <= 1'b1;
                            o_bid    <= r_wid;
                            o_bresp  <= (r_werr | w_wbeat_err) ? 2'b10 : 2'b00;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (i_bready) begin
                        o_bvalid  <= 1'b0;
                        o_bid     <= '0;
                        o_bresp   <= 2'b00;
                        o_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read engine: one registered memory read per beat, beat held until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_rcnt    <= '0;
            o_arready <= 1'b0;
            o_rvalid  <= 1'b0;
            o_rdata   <= '0;
            o_rid     <= '0;
            o_rresp   <= 2'b00;
            o_rlast   <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    o_arready <= 1'b1;
                    if (w_ar_hs) begin
                        o_arready <= 1'b0;
                        r_rcnt    <= '0;
                        r_rstate  <= R_READ;
                    end
                end
                R_READ: begin
                    o_rvalid <= 1'b1;
                    o_rid    <= r_rid;
                    o_rlast  <= (r_rcnt == r_rlen);
                    o_rresp  <= w_rbeat_err ? 2'b10 : 2'b00;
                    o_rdata  <= w_rbeat_err ? '0 : r_mem[f_idx(r_raddr)];
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (i_rready) begin
                        o_rvalid <= 1'b0;
                        o_rlast  <= 1'b0;
                        if (o_rlast) begin
                            o_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rcnt   <= r_rcnt + 4'd1;
                            r_rstate <= R_READ;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed testbench for axi_slave_mem (DATA_WIDTH=32, MEM_DEPTH=1024, BASE_ADDR=0).
module tb_axi_slave_mem;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_awaddr, i_araddr, i_wdata;
    logic [3:0]  i_awid, i_awlen, i_wid, i_wstrb, i_arid, i_arlen;
    logic [1:0]  i_awburst, i_arburst;
    logic        i_awvalid, i_wlast, i_wvalid, i_bready, i_arvalid, i_rready;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rlast, o_rvalid;
    logic [3:0]  o_bid, o_rid;
    logic [1:0]  o_bresp, o_rresp;
    logic [31:0] o_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wd [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_wait [16];
    logic [3:0]  rd_id;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;

    always #5 clk = ~clk;

    axi_slave_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024), .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .i_awaddr(i_awaddr), .i_awid(i_awid), .i_awlen(i_awlen), .i_awburst(i_awburst),
        .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wid(i_wid), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
        .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_araddr(i_araddr), .i_arid(i_arid), .i_arlen(i_arlen), .i_arburst(i_arburst),
        .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rid(o_rid), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready)
    );

    function automatic logic [49:0] all_outs();
        return {o_awready, o_wready, o_bvalid, o_bid, o_bresp, o_arready,
                o_rvalid, o_rdata, o_rid, o_rresp, o_rlast};
    endfunction

    // ---------------- bus drivers ----------------
    task automatic aw_phase(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                            input logic [1:0] burst);
        int t;
        @(negedge clk);
        i_awaddr = addr; i_awid = id; i_awlen = len; i_awburst = burst; i_awvalid = 1'b1;
        t = 0;
        while (!o_awready && t < 50) begin @(negedge clk); t++; end
        if (!o_awready) begin
            n_checks++; n_fail++;
            $display("FAIL aw_timeout: awready got 0 required 1");
        end
        @(negedge clk);
        i_awvalid = 1'b0;
    endtask

    task automatic w_beats(input int first, input int last_idx, input int len,
                           input logic [3:0] strb, input logic [3:0] wid);
        int t;
        for (int b = first; b <= last_idx; b++) begin
            i_wdata = wd[b]; i_wstrb = strb; i_wid = wid; i_wlast = (b == len); i_wvalid = 1'b1;
            t = 0;
            while (!o_wready && t < 50) begin @(negedge clk); t++; end
            if (!o_wready) begin
                n_checks++; n_fail++;
                $display("FAIL w_timeout: wready got 0 required 1 (beat %0d)", b);
            end
            @(negedge clk);
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
    endtask

    task automatic b_phase(output logic [3:0] id, output logic [1:0] resp);
        int t;
        t = 0;
        while (!o_bvalid && t < 50) begin @(negedge clk); t++; end
        if (!o_bvalid) begin
            n_checks++; n_fail++;
            $display("FAIL b_timeout: bvalid got 0 required 1");
        end
        id = o_bid; resp = o_bresp;
        i_bready = 1'b1;
        @(negedge clk);
        i_bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                            input logic [1:0] burst, input logic [3:0] strb, input logic [3:0] wid);
        aw_phase(addr, id, len, burst);
        w_beats(0, int'(len), int'(len), strb, wid);
        b_phase(b_id, b_resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                           input logic [1:0] burst);
        int t;
        @(negedge clk);
        i_araddr = addr; i_arid = id; i_arlen = len; i_arburst = burst; i_arvalid = 1'b1;
        t = 0;
        while (!o_arready && t < 50) begin @(negedge clk); t++; end
        if (!o_arready) begin
            n_checks++; n_fail++;
            $display("FAIL ar_timeout: arready got 0 required 1");
        end
        @(negedge clk);
        i_arvalid = 1'b0;
        i_rready  = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!o_rvalid && t < 50) begin @(negedge clk); t++; end
            if (!o_rvalid) begin
                n_checks++; n_fail++;
                $display("FAIL r_timeout: rvalid got 0 required 1 (beat %0d)", b);
            end
            rd_wait[b] = t; rd_data[b] = o_rdata; rd_resp[b] = o_rresp;
            rd_last[b] = o_rlast; rd_id = o_rid;
            @(negedge clk);
        end
        i_rready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_outs() !== 50'd0) begin
            n_fail++; $display("FAIL reset_outs: got %h required 0", all_outs());
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_awready !== 1'b1) begin n_fail++; $display("FAIL reset_awready: got %b required 1", o_awready); end
        n_checks++;
        if (o_arready !== 1'b1) begin n_fail++; $display("FAIL reset_arready: got %b required 1", o_arready); end
    endtask

    task automatic test_incr();
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) wd[i] = 32'hA000_0000 | i;
        do_write(32'h10, 4'd5, 4'd3, INCR, 4'hF, 4'd5);
        n_checks++;
        if (b_resp !== 2'b00) begin n_fail++; $display("FAIL incr_bresp: got %b required 00", b_resp); end
        n_checks++;
        if (b_id !== 4'd5) begin n_fail++; $display("FAIL incr_bid: got %0d required 5", b_id); end
        do_read(32'h10, 4'd9, 4'd3, INCR);
        for (int i = 0; i < 4; i++) begin
            exp = 32'hA000_0000 | i;
            n_checks++;
            if (rd_data[i] !== exp) begin
                n_fail++; $display("FAIL incr_rdata[%0d]: got %h required %h", i, rd_data[i], exp);
            end
            n_checks++;
            if (rd_resp[i] !== 2'b00) begin
                n_fail++; $display("FAIL incr_rresp[%0d]: got %b required 00", i, rd_resp[i]);
            end
            n_checks++;
            if (rd_last[i] !== (i == 3)) begin
                n_fail++; $display("FAIL incr_rlast[%0d]: got %b required %b", i, rd_last[i], (i == 3));
            end
        end
        n_checks++;
        if (rd_id !== 4'd9) begin n_fail++; $display("FAIL incr_rid: got %0d required 9", rd_id); end
        n_checks++;
        if (rd_wait[0] !== 1) begin n_fail++; $display("FAIL incr_first_latency: got %0d required 1", rd_wait[0]); end
        n_checks++;
        if (rd_wait[2] !== 1) begin n_fail++; $display("FAIL incr_beat_gap: got %0d required 1", rd_wait[2]); end
    endtask

    task automatic test_strobe();
        wd[0] = 32'h1122_3344;
        do_write(32'h40, 4'd1, 4'd0, INCR, 4'hF, 4'd1);
        wd[0] = 32'hAABB_CCDD;
        do_write(32'h40, 4'd1, 4'd0, INCR, 4'h3, 4'd1);
        do_read(32'h40, 4'd1, 4'd0, INCR);
        n_checks++;
        if (rd_data[0] !== 32'h1122_CCDD) begin
            n_fail++; $display("FAIL strobe_rdata: got %h required 1122ccdd", rd_data[0]);
        end
        n_checks++;
        if (rd_last[0] !== 1'b1) begin n_fail++; $display("FAIL strobe_rlast: got %b required 1", rd_last[0]); end
    endtask

    task automatic test_bursts();
        logic [31:0] exp_w [4];
        wd[0] = 32'h5700_0038; wd[1] = 32'h5700_003C; wd[2] = 32'h5700_0030; wd[3] = 32'h5700_0034;
        do_write(32'h38, 4'd2, 4'd3, WRAP, 4'hF, 4'd2);
        n_checks++;
        if (b_resp !== 2'b00) begin n_fail++; $display("FAIL wrap_bresp: got %b required 00", b_resp); end
        // Memory 0x30..0x3C in address order should hold beats 2,3,0,1.
        exp_w[0] = 32'h5700_0030; exp_w[1] = 32'h5700_0034; exp_w[2] = 32'h5700_0038; exp_w[3] = 32'h5700_003C;
        do_read(32'h30, 4'd2, 4'd3, INCR);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_data[i] !== exp_w[i]) begin
                n_fail++; $display("FAIL wrap_layout[%0d]: got %h required %h", i, rd_data[i], exp_w[i]);
            end
        end
        do_read(32'h38, 4'd2, 4'd3, WRAP);
        n_checks++;
        if (rd_data[2] !== 32'h5700_0030) begin
            n_fail++; $display("FAIL wrap_read_beat2: got %h required 57000030", rd_data[2]);
        end
        for (int i = 0; i < 4; i++) wd[i] = 32'h1C00_0038 + 32'(4 * i);
        do_write(32'h38, 4'd3, 4'd3, INCR, 4'hF, 4'd3);
        do_read(32'h3C, 4'd3, 4'd2, INCR);
        n_checks++;
        if (rd_data[2] !== 32'h1C00_0044) begin
            n_fail++; $display("FAIL incr_cross_0x44: got %h required 1c000044", rd_data[2]);
        end
        n_checks++;
        if (rd_data[0] !== 32'h1C00_003C) begin
            n_fail++; $display("FAIL incr_cross_0x3c: got %h required 1c00003c", rd_data[0]);
        end
        wd[0] = 32'hF000_0000; wd[1] = 32'hF000_0001;
        do_write(32'h80, 4'd4, 4'd1, FIXED, 4'hF, 4'd4);
        do_read(32'h80, 4'd4, 4'd0, INCR);
        n_checks++;
        if (rd_data[0] !== 32'hF000_0001) begin
            n_fail++; $display("FAIL fixed_rdata: got %h required f0000001", rd_data[0]);
        end
        wd[0] = 32'h0; wd[1] = 32'h0; wd[2] = 32'h0;
        do_write(32'h70, 4'd4, 4'd2, WRAP, 4'hF, 4'd4);
        n_checks++;
        if (b_resp !== 2'b10) begin n_fail++; $display("FAIL wrap_badlen_bresp: got %b required 10", b_resp); end
    endtask

    task automatic test_out_of_range();
        wd[0] = 32'h5A5A_5A5A;
        do_write(32'h0, 4'd6, 4'd0, INCR, 4'hF, 4'd6);
        wd[0] = 32'hDEAD_BEEF;
        do_write(32'h1000, 4'd6, 4'd0, INCR, 4'hF, 4'd6);
        n_checks++;
        if (b_resp !== 2'b10) begin n_fail++; $display("FAIL oor_bresp: got %b required 10", b_resp); end
        do_read(32'h0, 4'd6, 4'd0, INCR);
        n_checks++;
        if (rd_data[0] !== 32'h5A5A_5A5A) begin
            n_fail++; $display("FAIL oor_mem_unchanged: got %h required 5a5a5a5a", rd_data[0]);
        end
        do_read(32'h1000, 4'd6, 4'd0, INCR);
        n_checks++;
        if (rd_resp[0] !== 2'b10) begin n_fail++; $display("FAIL oor_rresp: got %b required 10", rd_resp[0]); end
        n_checks++;
        if (rd_data[0] !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: got %h required 0", rd_data[0]); end
        wd[0] = 32'hC000_0000; wd[1] = 32'hC000_0001;
        do_write(32'hFFC, 4'd7, 4'd1, INCR, 4'hF, 4'd7);
        n_checks++;
        if (b_resp !== 2'b10) begin n_fail++; $display("FAIL edge_bresp: got %b required 10", b_resp); end
        do_read(32'hFFC, 4'd7, 4'd1, INCR);
        n_checks++;
        if (rd_data[0] !== 32'hC000_0000) begin
            n_fail++; $display("FAIL edge_last_word: got %h required c0000000", rd_data[0]);
        end
        n_checks++;
        if (rd_resp[0] !== 2'b00) begin n_fail++; $display("FAIL edge_rresp0: got %b required 00", rd_resp[0]); end
        n_checks++;
        if (rd_resp[1] !== 2'b10) begin n_fail++; $display("FAIL edge_rresp1: got %b required 10", rd_resp[1]); end
        n_checks++;
        if (rd_data[1] !== 32'h0) begin n_fail++; $display("FAIL edge_rdata1: got %h required 0", rd_data[1]); end
    endtask

    task automatic test_bready_hold();
        wd[0] = 32'h600D_600D;
        aw_phase(32'h60, 4'd3, 4'd0, INCR);
        w_beats(0, 0, 0, 4'hF, 4'd3);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (o_bvalid !== 1'b1) begin n_fail++; $display("FAIL hold_bvalid[%0d]: got %b required 1", i, o_bvalid); end
            n_checks++;
            if (o_bid !== 4'd3) begin n_fail++; $display("FAIL hold_bid[%0d]: got %0d required 3", i, o_bid); end
            n_checks++;
            if (o_bresp !== 2'b00) begin n_fail++; $display("FAIL hold_bresp[%0d]: got %b required 00", i, o_bresp); end
            n_checks++;
            if (o_awready !== 1'b0) begin n_fail++; $display("FAIL hold_awready[%0d]: got %b required 0", i, o_awready); end
            @(negedge clk);
        end
        b_phase(b_id, b_resp);
        n_checks++;
        if (o_awready !== 1'b1) begin n_fail++; $display("FAIL hold_awready_after: got %b required 1", o_awready); end
        wd[0] = 32'h0;
        do_write(32'h64, 4'd2, 4'd0, INCR, 4'hF, 4'd7);
        n_checks++;
        if (b_resp !== 2'b10) begin n_fail++; $display("FAIL wid_bresp: got %b required 10", b_resp); end
        n_checks++;
        if (b_id !== 4'd2) begin n_fail++; $display("FAIL wid_bid: got %0d required 2", b_id); end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 4; i++) wd[i] = 32'hB000_0090 + 32'(i);
        aw_phase(32'h90, 4'd1, 4'd3, INCR);
        w_beats(0, 1, 3, 4'hF, 4'd1);
        rst = 1'b1;
        #1;
        n_checks++;
        if (all_outs() !== 50'd0) begin n_fail++; $display("FAIL midrst_outs: got %h required 0", all_outs()); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_awready !== 1'b1) begin n_fail++; $display("FAIL midrst_awready: got %b required 1", o_awready); end
        n_checks++;
        if (o_bvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_bresp: got %b required 0", o_bvalid); end
        do_read(32'h90, 4'd1, 4'd1, INCR);
        n_checks++;
        if (rd_data[0] !== 32'hB000_0090) begin
            n_fail++; $display("FAIL midrst_word0: got %h required b0000090", rd_data[0]);
        end
        n_checks++;
        if (rd_data[1] !== 32'hB000_0091) begin
            n_fail++; $display("FAIL midrst_word1: got %h required b0000091", rd_data[1]);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_awaddr = '0; i_awid = '0; i_awlen = '0; i_awburst = '0; i_awvalid = 1'b0;
        i_wdata = '0; i_wid = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
        i_araddr = '0; i_arid = '0; i_arlen = '0; i_arburst = '0; i_arvalid = 1'b0; i_rready = 1'b0;
        test_reset();
        test_incr();
        test_strobe();
        test_bursts();
        test_out_of_range();
        test_bready_hold();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
